// File: rtl/int_to_float_normalizer.sv
// rtl/int_to_float_normalizer.sv - 3-stage signed integer to sign/exponent/mantissa converter
// Stages: magnitude, leading-zero normalise, round-to-nearest-even; whole pipe stalls together.

module LeadingZeroCount #(
  parameter int BITWIDTH = 48,
  localparam int CW = $clog2(BITWIDTH + 1)
) (
  input  logic [BITWIDTH-1:0] data,
  output logic [CW-1:0]       count
);
  // Ascending scan so the highest set bit is the last to write the count.
  always_comb begin
    count = CW'(BITWIDTH);
    for (int i = 0; i < BITWIDTH; i++) begin
      if (data[i]) count = CW'(BITWIDTH - 1 - i);
    end
  end
endmodule

module int_to_float_normalizer #(
  parameter int IN_WIDTH   = 48,
  parameter int MANT_WIDTH = 24,
  parameter int EXP_WIDTH  = 8,
  parameter int EXP_BIAS   = 127
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sign,
  output logic [EXP_WIDTH-1:0]  out_exp,
  output logic [MANT_WIDTH-1:0] out_mant,
  output logic                  out_zero,
  output logic                  out_inexact
);
  localparam int LZC_W = $clog2(IN_WIDTH + 1);

  logic en;
  assign en       = !out_valid | out_ready;
  assign in_ready = en;

  // Stage 1: sign and magnitude; the most negative value wraps to 2^(IN_WIDTH-1).
  logic                s1_valid;
  logic                s1_sign;
  logic                s1_zero;
  logic [IN_WIDTH-1:0] s1_abs;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_abs   <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_sign  <= in_data[IN_WIDTH-1];
      s1_zero  <= (in_data == '0);
      s1_abs   <= in_data[IN_WIDTH-1] ? -in_data : in_data;
    end
  end

  // Stage 2: normalise so the leading one sits at the MSB.
  logic [LZC_W-1:0]     lzc;
  logic                 s2_valid;
  logic                 s2_sign;
  logic                 s2_zero;
  logic [IN_WIDTH-1:0]  s2_norm;
  logic [EXP_WIDTH-1:0] s2_exp;

  LeadingZeroCount #(.BITWIDTH(IN_WIDTH)) u_lzc (
    .data  (s1_abs),
    .count (lzc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b0;
      s2_norm  <= '0;
      s2_exp   <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_zero  <= s1_zero;
      s2_norm  <= s1_abs << lzc;
      s2_exp   <= EXP_WIDTH'(EXP_BIAS + IN_WIDTH - 1) - EXP_WIDTH'(lzc);
    end
  end

  // Stage 3: round to nearest, ties to even.
  logic [MANT_WIDTH-1:0] m;
  logic                  guard;
  logic                  sticky;
  logic                  round_up;
  logic [MANT_WIDTH:0]   m_sum;
  logic [MANT_WIDTH-1:0] mant_rnd;
  logic [EXP_WIDTH-1:0]  exp_rnd;

  always_comb begin
    m        = s2_norm[IN_WIDTH-1 -: MANT_WIDTH];
    guard    = s2_norm[IN_WIDTH-1-MANT_WIDTH];
    sticky   = |s2_norm[IN_WIDTH-2-MANT_WIDTH:0];
    round_up = guard & (sticky | m[0]);
    m_sum    = {1'b0, m} + {{MANT_WIDTH{1'b0}}, round_up};
    mant_rnd = m_sum[MANT_WIDTH-1:0];
    exp_rnd  = s2_exp;
    // All-ones mantissa rounding up carries into the exponent.
    if (m_sum[MANT_WIDTH]) begin
      mant_rnd = {1'b1, {(MANT_WIDTH-1){1'b0}}};
      exp_rnd  = s2_exp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_sign    <= 1'b0;
      out_exp     <= '0;
      out_mant    <= '0;
      out_zero    <= 1'b0;
      out_inexact <= 1'b0;
    end else if (en) begin
      out_valid <= s2_valid;
      out_zero  <= s2_zero;
      if (s2_zero) begin
        out_sign    <= 1'b0;
        out_exp     <= '0;
        out_mant    <= '0;
        out_inexact <= 1'b0;
      end else begin
        out_sign    <= s2_sign;
        out_exp     <= exp_rnd;
        out_mant    <= mant_rnd;
        out_inexact <= guard | sticky;
      end
    end
  end
endmodule

// File: tb/tb_int_to_float_normalizer.sv
// tb/tb_int_to_float_normalizer.sv - directed vector bench for int_to_float_normalizer
// Table vectors plus stall, random-stream and mid-stream reset sequences.

module tb_int_to_float_normalizer;
  typedef struct {
    logic [47:0] data;
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] mant;
    logic        zero;
    logic        inexact;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [47:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [23:0] out_mant;
  logic        out_zero;
  logic        out_inexact;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 0;
  bit lat_chk = 1;
  vec_t exp_q[$];
  int   cyc_q[$];
  vec_t vecs[12];

  int_to_float_normalizer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sign    (out_sign),
    .out_exp     (out_exp),
    .out_mant    (out_mant),
    .out_zero    (out_zero),
    .out_inexact (out_inexact)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Independent reference: locate the MSB, shift right, round on the remainder.
  function automatic vec_t model(input logic [47:0] d);
    vec_t r;
    longint unsigned a, q, rem, half;
    int p, k;
    r.data = d; r.sign = 0; r.exp = 0; r.mant = 0; r.zero = 0; r.inexact = 0;
    a = d[47] ? (64'h1_0000_0000_0000 - {16'h0, d}) : {16'h0, d};
    if (a == 0) begin
      r.zero = 1;
      return r;
    end
    p = 0;
    for (int i = 0; i < 64; i++) if (a[i]) p = i;
    if (p <= 23) begin
      q = a << (23 - p);
    end else begin
      k = p - 23;
      q = a >> k;
      rem = a & ((64'd1 << k) - 1);
      half = 64'd1 << (k - 1);
      r.inexact = (rem != 0);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        p = p + 1;
      end
    end
    r.sign = d[47];
    r.exp  = 8'(127 + p);
    r.mant = q[23:0];
    return r;
  endfunction

  initial begin : monitor
    vec_t e;
    int c;
    bit prev_stall = 0;
    logic [34:0] snap = '0;
    forever begin
      @(negedge clk);
      if (mon_en && out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output got sign=%0d exp=%0d mant=%h zero=%0d", out_sign, out_exp, out_mant, out_zero);
        end else begin
          e = exp_q.pop_front();
          c = cyc_q.pop_front();
          if (out_sign !== e.sign || out_exp !== e.exp || out_mant !== e.mant ||
              out_zero !== e.zero || out_inexact !== e.inexact) begin
            failures++;
            $display("FAIL result in=%h got s=%0d e=%0d m=%h z=%0d x=%0d want s=%0d e=%0d m=%h z=%0d x=%0d",
                     e.data, out_sign, out_exp, out_mant, out_zero, out_inexact,
                     e.sign, e.exp, e.mant, e.zero, e.inexact);
          end
          if (lat_chk) begin
            checks++;
            if (cyc - c != 3) begin
              failures++;
              $display("FAIL latency in=%h got %0d want 3", e.data, cyc - c);
            end
          end
        end
      end
      if (mon_en && out_valid && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL in_ready_stall got %0d want 0", in_ready);
        end
        if (prev_stall) begin
          checks++;
          if ({out_sign, out_exp, out_mant, out_zero, out_inexact} !== snap) begin
            failures++;
            $display("FAIL hold got %h want %h", {out_sign, out_exp, out_mant, out_zero, out_inexact}, snap);
          end
        end
        prev_stall = 1;
        snap = {out_sign, out_exp, out_mant, out_zero, out_inexact};
      end else begin
        prev_stall = 0;
      end
    end
  end

  task automatic send(input logic [47:0] d, input vec_t e, input bit rec);
    bit ok = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout in=%h got in_ready=0 want 1", d);
    end else if (rec) begin
      exp_q.push_back(e);
      cyc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_%s got %0d pending want 0", name, exp_q.size());
    end
  endtask

  initial begin
    int stale;
    logic [47:0] d;
    vecs[0]  = '{48'h0000_0000_0001, 1'b0, 8'd127, 24'h800000, 1'b0, 1'b0};
    vecs[1]  = '{48'hFFFF_FFFF_FFFF, 1'b1, 8'd127, 24'h800000, 1'b0, 1'b0};
    vecs[2]  = '{48'h0000_0000_0000, 1'b0, 8'd0,   24'h000000, 1'b1, 1'b0};
    vecs[3]  = '{48'h0000_0100_0001, 1'b0, 8'd151, 24'h800000, 1'b0, 1'b1};
    vecs[4]  = '{48'h0000_0100_0003, 1'b0, 8'd151, 24'h800002, 1'b0, 1'b1};
    vecs[5]  = '{48'h0000_01FF_FFFF, 1'b0, 8'd152, 24'h800000, 1'b0, 1'b1};
    vecs[6]  = '{48'h8000_0000_0000, 1'b1, 8'd174, 24'h800000, 1'b0, 1'b0};
    vecs[7]  = '{48'h0000_00FF_FFFF, 1'b0, 8'd150, 24'hFFFFFF, 1'b0, 1'b0};
    vecs[8]  = '{48'h0000_0000_0005, 1'b0, 8'd129, 24'hA00000, 1'b0, 1'b0};
    vecs[9]  = '{48'hFFFF_FFFF_FFFA, 1'b1, 8'd129, 24'hC00000, 1'b0, 1'b0};
    vecs[10] = '{48'h7FFF_FFFF_FFFF, 1'b0, 8'd174, 24'h800000, 1'b0, 1'b1};
    vecs[11] = '{48'h0000_0100_0002, 1'b0, 8'd151, 24'h800001, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, out_sign, out_exp, out_mant, out_zero, out_inexact} !== '0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state got v=%0d s=%0d e=%0d m=%h z=%0d x=%0d rdy=%0d want all 0 rdy=1",
               out_valid, out_sign, out_exp, out_mant, out_zero, out_inexact, in_ready);
    end
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1;

    send(vecs[0].data, vecs[0], 1);
    drain("first");
    @(posedge clk);
    #1;
    for (int i = 1; i < 12; i++) send(vecs[i].data, vecs[i], 1);
    drain("table");

    lat_chk = 0;
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          d = 48'({$urandom, $urandom});
          d = 48'($signed(d) >>> $urandom_range(0, 40));
          send(d, model(d), 1);
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("stall");

    mon_en = 0;
    @(posedge clk);
    #1;
    for (int i = 3; i < 6; i++) send(vecs[i].data, vecs[i], 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_flush got out_valid=%0d want 0", out_valid);
    end
    stale = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checks++;
    if (stale != 0) begin
      failures++;
      $display("FAIL stale_after_reset got %0d want 0", stale);
    end
    mon_en  = 1;
    lat_chk = 1;
    @(posedge clk);
    #1;
    send(vecs[9].data, vecs[9], 1);
    drain("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
